cla_pipe_adder: RTL and testbench

- Two-stage pipelined carry-lookahead adder/subtractor for the MiniSRC datapath.
- Consumes per-bit generate/propagate/sum terms, formed the same way as the bit-slice cell's: g = x&y, p = x|y, s = x^y^c.
- Builds 4-bit group lookahead and produces a registered WIDTH-bit result.
- Sits downstream of the bit-slice stage and feeds the ALU result mux.
- Valid/ready handshake on both sides, so the ALU can stall it.

---
 rtl/cla_pipe_adder.sv | 208 ++++++++++++++++++++
 tb/tb_cla_pipe_adder.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_pipe_adder.sv
// ---------------------------------------------------------------------------
// cla_pipe_adder
//
// Two-stage pipelined carry-lookahead adder/subtractor for the MiniSRC datapath.
// Stage 1 conditions the operands for subtraction. It registers the per-bit
// generate, propagate and half-sum terms, plus the 4-bit group generate and
// propagate. Stage 2 resolves the group carry chain and the intra-group
// carries. It then registers the final sum and carry-out.
// A valid/ready handshake on both sides lets the ALU stall the pipe.
//
// Ports:
//   clock      in   rising-edge clock
//   clear_n    in   asynchronous active-low reset
//   in_valid   in   operand beat valid
//   in_ready   out  block can accept a beat this cycle
//   a, b       in   WIDTH-bit operands
//   cin        in   carry in (ignored when sub=1)
//   sub        in   1 = compute a - b
//   out_valid  out  result valid
//   out_ready  in   downstream accepts result
//   sum        out  WIDTH-bit result
//   cout       out  carry out of MSB (subtract: 1 = no borrow)
//   overflow   out  signed overflow (CLA_FLAGS_EN builds only, else 0)
//   zero       out  sum == 0        (CLA_FLAGS_EN builds only, else 0)
//
// Optional feature macro: CLA_FLAGS_EN
//   When it is defined, overflow and zero are registered in stage 2.
//   When it is undefined, both are tied low and no flag logic exists.
// ---------------------------------------------------------------------------
module cla_pipe_adder #(
    parameter int WIDTH = 32,
    parameter int GROUP = 4
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int NG = WIDTH / GROUP;

    // Group generate: g3 | p3g2 | p3p2g1 | p3p2p1g0, folded from the LSB up.
    function automatic logic grp_gen(input logic [GROUP-1:0] gg,
                                     input logic [GROUP-1:0] pp);
        logic acc;
        acc = 1'b0;
        for (int j = 0; j < GROUP; j++) begin
            acc = gg[j] | (pp[j] & acc);
        end
        return acc;
    endfunction

    // ---------------- handshake ----------------
    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    logic s1_load, s2_load;

    assign s2_load  = s1_valid_q & (~s2_valid_q | out_ready);
    assign in_ready = ~s1_valid_q | ~s2_valid_q | out_ready;
    assign s1_load  = in_valid & in_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        if (s1_load)      s1_valid_d = 1'b1;
        else if (s2_load) s1_valid_d = 1'b0;

        s2_valid_d = s2_valid_q;
        if (s2_load)        s2_valid_d = 1'b1;
        else if (out_ready) s2_valid_d = 1'b0;
    end

    // ---------------- operand conditioning + stage 1 terms ----------------
    logic [WIDTH-1:0] bb;
    logic             c0;
    logic [WIDTH-1:0] g_d, p_d, h_d;
    logic [NG-1:0]    grp_g_d, grp_p_d;

    assign bb  = b ^ {WIDTH{sub}};
    assign c0  = sub | cin;
    assign g_d = a & bb;
    assign p_d = a | bb;
    assign h_d = a ^ bb;

    genvar gi;
    generate
        for (gi = 0; gi < NG; gi++) begin : g_group
            assign grp_g_d[gi] = grp_gen(g_d[gi*GROUP +: GROUP], p_d[gi*GROUP +: GROUP]);
            assign grp_p_d[gi] = &p_d[gi*GROUP +: GROUP];
        end
    endgenerate

    logic [WIDTH-1:0] g_q, p_q, h_q;
    logic [NG-1:0]    grp_g_q, grp_p_q;
    logic             c0_q;

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            s1_valid_q <= 1'b0;
            g_q        <= '0;
            p_q        <= '0;
            h_q        <= '0;
            grp_g_q    <= '0;
            grp_p_q    <= '0;
            c0_q       <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (s1_load) begin
                g_q     <= g_d;
                p_q     <= p_d;
                h_q     <= h_d;
                grp_g_q <= grp_g_d;
                grp_p_q <= grp_p_d;
                c0_q    <= c0;
            end
        end
    end

    // ---------------- stage 2: carry resolution ----------------
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;

    always_comb begin : s2_carry
        logic grp_c;
        logic run_c;
        grp_c  = c0_q;
        run_c  = 1'b0;
        sum_d  = '0;
        for (int k = 0; k < NG; k++) begin
            // Each group's ripple starts from its lookahead carry-in.
            // The ripple carry out of the group's top bit is recomputed here
            // but then superseded by the group carry chain.
            run_c = grp_c;
            for (int j = 0; j < GROUP; j++) begin
                sum_d[k*GROUP + j] = h_q[k*GROUP + j] ^ run_c;
                run_c = g_q[k*GROUP + j] | (p_q[k*GROUP + j] & run_c);
            end
            grp_c = grp_g_q[k] | (grp_p_q[k] & grp_c);
        end
        cout_d = grp_c;
    end

    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            s2_valid_q <= 1'b0;
            sum_q      <= '0;
            cout_q     <= 1'b0;
        end else begin
            s2_valid_q <= s2_valid_d;
            if (s2_load) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;

    // ---------------- optional flags ----------------
`ifdef CLA_FLAGS_EN
    logic a_msb_q, bb_msb_q;
    logic ovf_q, zero_q;
    logic ovf_d, zero_d;

    // Operands of equal sign whose result flips sign => signed overflow.
    assign ovf_d  = (a_msb_q == bb_msb_q) & (sum_d[WIDTH-1] != a_msb_q);
    assign zero_d = (sum_d == '0);

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            a_msb_q  <= 1'b0;
            bb_msb_q <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            if (s1_load) begin
                a_msb_q  <= a[WIDTH-1];
                bb_msb_q <= bb[WIDTH-1];
            end
            if (s2_load) begin
                ovf_q  <= ovf_d;
                zero_q <= zero_d;
            end
        end
    end

    assign overflow = ovf_q;
    assign zero     = zero_q;
`else
    assign overflow = 1'b0;
    assign zero     = 1'b0;
`endif

endmodule

// File: tb/tb_cla_pipe_adder.sv
// ---------------------------------------------------------------------------
// tb_cla_pipe_adder
//
// Directed-vector bench for cla_pipe_adder (WIDTH=32, GROUP=4).
// The reference model is plain integer arithmetic. A queue holds the expected
// results, and the monitor pops one each time a result is consumed. It also
// checks that stalled outputs hold stable. Each directed vector also has a
// hand-computed literal check.
// ---------------------------------------------------------------------------
module tb_cla_pipe_adder;

    localparam int W = 32;

`ifdef CLA_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         clear_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic         cin, sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout, overflow, zero;

    always #5 clock = ~clock;

    cla_pipe_adder #(.WIDTH(W), .GROUP(4)) dut (
        .clock     (clock),
        .clear_n   (clear_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow),
        .zero      (zero)
    );

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         v;
        logic         z;
    } exp_t;

    exp_t expq[$];
    int   checks   = 0;
    int   errors   = 0;
    int   produced = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: ordinary modular arithmetic plus true signed range test.
    function automatic exp_t model(input logic [W-1:0] aa, input logic [W-1:0] bv,
                                   input logic ci, input logic sb);
        exp_t        e;
        logic [W:0]  full;
        longint      sr;
        longint      smax;
        longint      smin;
        bit          ov;
        smax = (longint'(1) <<< (W-1)) - 1;
        smin = -(longint'(1) <<< (W-1));
        if (sb) begin
            e.s = aa - bv;
            e.c = (aa >= bv);
            sr  = longint'($signed(aa)) - longint'($signed(bv));
        end else begin
            full = {1'b0, aa} + {1'b0, bv} + {{W{1'b0}}, ci};
            e.s  = full[W-1:0];
            e.c  = full[W];
            sr   = longint'($signed(aa)) + longint'($signed(bv)) + longint'(ci);
        end
        ov  = (sr > smax) || (sr < smin);
        e.v = FLAGS & ov;
        e.z = FLAGS & (e.s == '0);
        return e;
    endfunction

    // Present one beat; hold it until accepted (bounded), then queue its result.
    task automatic drive_beat(input logic [W-1:0] av, input logic [W-1:0] bv,
                              input logic ci, input logic sb);
        int n;
        @(negedge clock);
        a = av; b = bv; cin = ci; sub = sb; in_valid = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clock);
            #1;
            n++;
        end
        if (!in_ready) begin
            errors++;
            $display("FAIL accept_timeout: got in_ready=%0b expected 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        expq.push_back(model(av, bv, ci, sb));
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    // Monitor: compare every consumed result, and check that stalled outputs hold.
    logic         stall_pending = 1'b0;
    logic [W+2:0] held;

    always @(negedge clock) begin
        exp_t e;
        #2;
        if (!clear_n) begin
            stall_pending = 1'b0;
        end else begin
            if (stall_pending) begin
                chk("stall_hold_valid", {63'd0, out_valid}, 64'd1);
                chk("stall_hold_data", {29'd0, sum, cout, overflow, zero}, {29'd0, held});
            end
            stall_pending = 1'b0;
            if (out_valid) begin
                if (out_ready) begin
                    if (expq.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_result: got sum=%0h expected no result", sum);
                    end else begin
                        e = expq.pop_front();
                        produced++;
                        chk("model_sum",  {32'd0, sum}, {32'd0, e.s});
                        chk("model_cout", {63'd0, cout}, {63'd0, e.c});
                        chk("model_ovf",  {63'd0, overflow}, {63'd0, e.v});
                        chk("model_zero", {63'd0, zero}, {63'd0, e.z});
                    end
                end else begin
                    held          = {sum, cout, overflow, zero};
                    stall_pending = 1'b1;
                end
            end
        end
    end

    // One unstalled beat, with latency and hand-computed result checks.
    task automatic run_single(input string name,
                              input logic [W-1:0] av, input logic [W-1:0] bv,
                              input logic ci, input logic sb,
                              input logic [W-1:0] es, input logic ec,
                              input logic ev, input logic ez);
        drive_beat(av, bv, ci, sb);
        @(negedge clock); #3;
        chk({name, "_lat1"}, {63'd0, out_valid}, 64'd0);
        @(negedge clock); #3;
        chk({name, "_lat2"}, {63'd0, out_valid}, 64'd1);
        chk({name, "_sum"},  {32'd0, sum}, {32'd0, es});
        chk({name, "_cout"}, {63'd0, cout}, {63'd0, ec});
`ifdef CLA_FLAGS_EN
        chk({name, "_ovf"},  {63'd0, overflow}, {63'd0, ev});
        chk({name, "_zero"}, {63'd0, zero}, {63'd0, ez});
`else
        chk({name, "_ovf_off"},  {63'd0, overflow}, {63'd0, ev & 1'b0});
        chk({name, "_zero_off"}, {63'd0, zero}, {63'd0, ez & 1'b0});
`endif
    endtask

    initial begin
        int n;
        int base;
        clear_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;

        // Reset
        repeat (3) @(negedge clock);
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_sum", {32'd0, sum}, 64'd0);
        chk("rst_cout", {63'd0, cout}, 64'd0);
        @(negedge clock);
        clear_n = 1'b1;
        #1;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Directed vectors (out_ready=1)
        run_single("add_grp_carry", 32'h0000_000F, 32'h0000_0001, 1'b0, 1'b0,
                   32'h0000_0010, 1'b0, 1'b0, 1'b0);
        run_single("full_ripple", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0,
                   32'h0000_0000, 1'b1, 1'b0, 1'b1);
        run_single("sub_borrow", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1,
                   32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        run_single("signed_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
                   32'h8000_0000, 1'b0, 1'b1, 1'b0);
        run_single("sub_equal", 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1,
                   32'h0000_0000, 1'b1, 1'b0, 1'b1);

        // Backpressure: 4 beats back-to-back, out_ready low for 3 stalled edges
        base = produced;
        @(negedge clock);
        out_ready = 1'b0;
        fork
            begin
                drive_beat(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0);
                drive_beat(32'hFFFF_0000, 32'h0001_0000, 1'b0, 1'b0);
                drive_beat(32'd100, 32'd50, 1'b0, 1'b1);
                drive_beat(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
            end
            begin
                @(negedge clock);
                @(negedge clock);
                @(negedge clock);
                #1;
                chk("bp_in_ready_drop", {63'd0, in_ready}, 64'd0);
                chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
                chk("bp_first_sum", {32'd0, sum}, 64'h3);
                repeat (3) @(negedge clock);
                out_ready = 1'b1;
            end
        join
        n = 0;
        while (expq.size() != 0 && n < 50) begin
            @(negedge clock);
            n++;
        end
        @(negedge clock); #3;
        chk("bp_results_count", produced - base, 4);
        chk("bp_queue_empty", expq.size(), 0);

        // Reset mid-stream
        @(negedge clock);
        out_ready = 1'b0;
        drive_beat(32'h0000_00AA, 32'h0000_0055, 1'b0, 1'b0);
        drive_beat(32'h0000_0300, 32'h0000_0100, 1'b0, 1'b1);
        @(negedge clock); #3;
        chk("mid_pre_valid", {63'd0, out_valid}, 64'd1);
        clear_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_sum", {32'd0, sum}, 64'd0);
        expq.delete();
        repeat (2) @(negedge clock);
        clear_n   = 1'b1;
        out_ready = 1'b1;
        repeat (6) @(negedge clock);
        #3;
        chk("mid_no_stale", {63'd0, out_valid}, 64'd0);
        chk("mid_in_ready", {63'd0, in_ready}, 64'd1);

        // The pipe must still work after the mid-stream reset.
        run_single("post_rst_add", 32'h0000_1234, 32'h0000_0FFF, 1'b1, 1'b0,
                   32'h0000_2234, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clock);
        chk("final_queue_empty", expq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
